acc_flag_reg: RTL and testbench
===============================

# acc_flag_reg

Accumulator and status-flag stage placed directly downstream of the 8-bit add/subtract ALU. It registers the 9-bit ALU result into an 8-bit accumulator and derives the Z, N, C and V flags. It also provides a 4-deep context stack that saves and restores the accumulator and flags for interrupt entry and exit. The sequencer reads the accumulator and flags from this block for write-back and conditional branches.

## Interface
Parameters:
- STACK_DEPTH, 4, number of context-stack entries (power of two, 2..8)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state
- alu_out  input  9  ALU result; [8] = adder carry-out, [7:0] = sum
- op_a_msb  input  1  bit 7 of the ALU first operand (reg_in1[7])
- op_b_msb  input  1  bit 7 of the raw ALU second operand, before inversion (reg_in2[7])
- sub_nadd  input  1  ALU mode: 1 = subtract, 0 = add
- alu_we  input  1  capture ALU result and all four flags this cycle
- load_en  input  1  load acc from load_data
- load_data  input  8  direct accumulator load value
- ctx_save  input  1  push {acc, flags} onto context stack
- ctx_restore  input  1  pop context stack into {acc, flags}
- acc  output  8  accumulator
- flag_z, flag_n, flag_c, flag_v  output  1 each  status flags
- upd_valid  output  1  one-cycle pulse: acc/flags changed last edge
- stk_empty, stk_full  output  1 each  context-stack status
- stk_err  output  1  sticky stack-misuse error

## Operation
- Flag rules on alu_we:
  - Z = (alu_out[7:0] == 0)
  - N = alu_out[7]
  - C = alu_out[8] ^ sub_nadd, so C is the carry on add and the borrow on subtract.
  - V = (op_a_msb == (op_b_msb ^ sub_nadd)) && (alu_out[7] != op_a_msb)
- On load_en: acc = load_data; Z and N are recomputed from load_data; C and V are held.
- Write priority for the same cycle: ctx_restore > alu_we > load_en. A lower-priority write in that cycle is dropped silently.
- Context stack: an array of STACK_DEPTH entries, 12 bits each ({acc, Z, N, C, V}), plus a pointer/count register sp of width clog2(STACK_DEPTH)+1.
  - Push writes the pre-edge acc and flags to entry[sp], then sp increments.
  - Pop decrements sp and loads entry[sp-1] into acc and flags.
- ctx_save in the same cycle as alu_we or load_en: the push stores the old (pre-update) values and the update also takes effect. This supports save-then-compute.
- Misuse cases, each of which sets stk_err and changes neither sp nor any entry:
  - ctx_save with ctx_restore in the same cycle: both are ignored. alu_we and load_en that cycle proceed normally.
  - Push while full (sp == STACK_DEPTH): ignored.
  - Pop while empty (sp == 0): ignored. A lower-priority alu_we or load_en that cycle proceeds normally.
- stk_err clears only on reset.
- Status outputs: stk_empty = (sp == 0) and stk_full = (sp == STACK_DEPTH), both derived combinationally from sp.

## Timing
- Reset values: acc=0x00, Z=1, N=0, C=0, V=0, sp=0, stk_empty=1, stk_full=0, stk_err=0, upd_valid=0. Stack entry contents are don't-care.
- Reset overrides every other input in the same cycle.
- Latency: inputs sampled at edge k; acc and flags are visible after edge k. upd_valid is high for exactly the cycle after any accepted alu_we, load_en or successful pop.
- Back-to-back alu_we every cycle is supported at full throughput. Each cycle's result overwrites the previous one.
- A push followed immediately by a pop, in consecutive cycles, returns exactly the pushed value.
- Asserting reset in the middle of a sequence discards the stack contents: sp returns to 0.
- No combinational path exists from any input to any output other than stk_empty and stk_full, which depend only on sp.

## Test plan
- Reset then add: alu_out=0x1_05, sub_nadd=0, op_a_msb=0, op_b_msb=0, alu_we -> acc=0x05, C=1, Z=0, N=0, V=0. upd_valid pulses once.
- Subtract, equal operands: 0x40-0x40 gives alu_out=0x1_00, sub_nadd=1, op_a_msb=0, op_b_msb=0 -> acc=0x00, Z=1, C=0 (no borrow), V=0.
- Signed overflow: 0x7F+0x01 gives alu_out=0x0_80, op_a_msb=0, op_b_msb=0, sub_nadd=0 -> N=1, V=1, C=0. Then load_en with 0x00 -> acc=0x00, Z=1, N=0, V still 1.
- Stack fill and drain:
  - Push 4 distinct contexts -> stk_full=1.
  - 5th push -> stk_err=1, sp unchanged.
  - 4 pops -> contexts return in LIFO order.
  - Pop on empty -> stk_err stays 1, acc unchanged.
- Simultaneous events:
  - ctx_save with alu_we (acc 0x11 to 0x22) -> stack holds 0x11, acc=0x22.
  - ctx_restore with alu_we -> restored value wins.
  - ctx_save with ctx_restore -> stk_err=1, sp unchanged.
- Reset mid-operation: after 2 pushes, reset=0 for one cycle -> every output returns to its reset value and stk_empty=1.

Source files
------------

// File: rtl/acc_flag_reg.sv
// acc_flag_reg
//   Accumulator and status-flag stage behind the 8-bit add/subtract ALU.
//   It registers the ALU sum into an 8-bit accumulator and derives the
//   Z/N/C/V flags. A small LIFO context stack saves and restores
//   {acc, Z, N, C, V} on interrupt entry and exit.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   alu_out      ALU result, [8] = carry-out, [7:0] = sum
//   op_a_msb     bit 7 of the first ALU operand
//   op_b_msb     bit 7 of the raw second operand (before inversion)
//   sub_nadd     1 = subtract, 0 = add
//   alu_we       capture ALU result and all four flags
//   load_en      load acc from load_data (Z/N recomputed, C/V held)
//   load_data    direct accumulator load value
//   ctx_save     push {acc, flags}
//   ctx_restore  pop into {acc, flags}
//   acc          accumulator
//   flag_z/n/c/v status flags
//   upd_valid    acc/flags changed at the last edge
//   stk_empty    stack pointer is zero (combinational from sp)
//   stk_full     stack pointer equals depth (combinational from sp)
//   stk_err      sticky stack-misuse error, cleared only by reset
module acc_flag_reg #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] alu_out,
  input  logic       op_a_msb,
  input  logic       op_b_msb,
  input  logic       sub_nadd,
  input  logic       alu_we,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic       ctx_save,
  input  logic       ctx_restore,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_c,
  output logic       flag_v,
  output logic       upd_valid,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err
);

  localparam int PW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [7:0]     acc_q, acc_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
  logic           c_q, c_d;
  logic           v_q, v_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           upd_q, upd_d;
  logic [11:0]    stack_q [STACK_DEPTH];

  logic           empty, full;
  logic           push_ok, pop_ok, misuse;
  logic [PW-1:0]  push_idx, pop_idx;
  logic [11:0]    cur_ctx;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_FULL);
  assign cur_ctx = {acc_q, z_q, n_q, c_q, v_q};

  // Save and restore together cancel each other; each alone is rejected
  // when the stack cannot honour it.
  assign push_ok = ctx_save & ~ctx_restore & ~full;
  assign pop_ok  = ctx_restore & ~ctx_save & ~empty;
  assign misuse  = (ctx_save & ctx_restore)
                 | (ctx_save & ~ctx_restore & full)
                 | (ctx_restore & ~ctx_save & empty);

  assign push_idx = sp_q[PW-1:0];
  assign pop_idx  = sp_q[PW-1:0] - PW'(1);

  always_comb begin
    acc_d = acc_q;
    z_d   = z_q;
    n_d   = n_q;
    c_d   = c_q;
    v_d   = v_q;
    if (pop_ok) begin
      {acc_d, z_d, n_d, c_d, v_d} = stack_q[pop_idx];
    end else if (alu_we) begin
      acc_d = alu_out[7:0];
      z_d   = (alu_out[7:0] == 8'h00);
      n_d   = alu_out[7];
      // Carry-out is inverted on subtract so C reads as borrow.
      c_d   = alu_out[8] ^ sub_nadd;
      // Effective operand signs agree but the result sign differs.
      v_d   = (op_a_msb == (op_b_msb ^ sub_nadd)) && (alu_out[7] != op_a_msb);
    end else if (load_en) begin
      acc_d = load_data;
      z_d   = (load_data == 8'h00);
      n_d   = load_data[7];
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_ok) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  assign err_d = err_q | misuse;
  assign upd_d = pop_ok | alu_we | load_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= 8'h00;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      sp_q  <= '0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      n_q   <= n_d;
      c_q   <= c_d;
      v_q   <= v_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      upd_q <= upd_d;
    end
  end

  // Entry contents are meaningless once sp is cleared, so they carry no reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      stack_q[push_idx] <= cur_ctx;
    end
  end

  assign acc       = acc_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign upd_valid = upd_q;
  assign stk_empty = empty;
  assign stk_full  = full;
  assign stk_err   = err_q;

endmodule

// File: tb/tb_acc_flag_reg.sv
module tb_acc_flag_reg;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] alu_out;
  logic       op_a_msb, op_b_msb, sub_nadd;
  logic       alu_we, load_en;
  logic [7:0] load_data;
  logic       ctx_save, ctx_restore;
  logic [7:0] acc;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic       upd_valid, stk_empty, stk_full, stk_err;

  acc_flag_reg #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .op_a_msb(op_a_msb),
    .op_b_msb(op_b_msb), .sub_nadd(sub_nadd), .alu_we(alu_we),
    .load_en(load_en), .load_data(load_data), .ctx_save(ctx_save),
    .ctx_restore(ctx_restore), .acc(acc), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .upd_valid(upd_valid),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] acc;
    logic [3:0] flg;  // {Z,N,C,V}
    logic [3:0] st;   // {upd_valid, stk_empty, stk_full, stk_err}
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  m_acc;
  logic        m_z, m_n, m_c, m_v, m_err;
  int          m_sp;
  logic [11:0] m_stk [DEPTH];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_strobes();
    alu_we = 0; load_en = 0; ctx_save = 0; ctx_restore = 0; reset = 1;
  endtask

  // Predict the post-edge outputs from the current inputs, queue them,
  // clock once and compare against the head of the queue.
  task automatic step(input string tag);
    exp_t e;
    logic [11:0] old;
    logic push, pop, upd;
    if (!reset) begin
      m_acc = 8'h00; m_z = 1; m_n = 0; m_c = 0; m_v = 0;
      m_sp = 0; m_err = 0; upd = 0;
    end else begin
      old  = {m_acc, m_z, m_n, m_c, m_v};
      pop  = ctx_restore && !ctx_save && m_sp > 0;
      push = ctx_save && !ctx_restore && m_sp < DEPTH;
      if ((ctx_save && ctx_restore) || (ctx_save && !ctx_restore && m_sp == DEPTH) ||
          (ctx_restore && !ctx_save && m_sp == 0))
        m_err = 1;
      upd = pop || alu_we || load_en;
      if (pop) begin
        m_sp = m_sp - 1;
        {m_acc, m_z, m_n, m_c, m_v} = m_stk[m_sp];
      end else if (alu_we) begin
        m_acc = alu_out[7:0];
        m_z = (alu_out[7:0] == 0);
        m_n = alu_out[7];
        m_c = alu_out[8] ^ sub_nadd;
        m_v = (op_a_msb == (op_b_msb ^ sub_nadd)) && (alu_out[7] != op_a_msb);
      end else if (load_en) begin
        m_acc = load_data;
        m_z = (load_data == 0);
        m_n = load_data[7];
      end
      if (push) begin
        m_stk[m_sp] = old;
        m_sp = m_sp + 1;
      end
    end
    e.acc = m_acc;
    e.flg = {m_z, m_n, m_c, m_v};
    e.st  = {upd, m_sp == 0, m_sp == DEPTH, m_err};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, {8'h00, acc}, {8'h00, e.acc});
      chk({tag, "_flg"}, {12'h000, flag_z, flag_n, flag_c, flag_v}, {12'h000, e.flg});
      chk({tag, "_st"}, {12'h000, upd_valid, stk_empty, stk_full, stk_err}, {12'h000, e.st});
    end
    clear_strobes();
  endtask

  task automatic alu(input logic [8:0] r, input logic a, input logic b, input logic s);
    alu_out = r; op_a_msb = a; op_b_msb = b; sub_nadd = s; alu_we = 1;
  endtask

  logic [7:0] vals [4];

  initial begin
    alu_out = 0; op_a_msb = 0; op_b_msb = 0; sub_nadd = 0; load_data = 0;
    clear_strobes();
    vals[0] = 8'h3C; vals[1] = 8'h81; vals[2] = 8'h00; vals[3] = 8'hF5;

    reset = 0; step("rst0");
    reset = 0; step("rst1");
    chk("rst_acc", {8'h00, acc}, 16'h0000);
    chk("rst_flags", {12'h0, flag_z, flag_n, flag_c, flag_v}, 16'h0008);
    chk("rst_stat", {12'h0, upd_valid, stk_empty, stk_full, stk_err}, 16'h0004);

    // add with carry-out
    alu(9'h105, 0, 0, 0); step("add");
    chk("tp_add_acc", {8'h00, acc}, 16'h0005);
    chk("tp_add_flg", {12'h0, flag_z, flag_n, flag_c, flag_v}, 16'h0002);
    chk("tp_add_upd", {15'h0, upd_valid}, 16'h0001);
    step("idle");
    chk("tp_upd_once", {15'h0, upd_valid}, 16'h0000);

    // equal subtract: no borrow
    alu(9'h100, 0, 0, 1); step("sub_eq");
    chk("tp_sub_flg", {12'h0, flag_z, flag_n, flag_c, flag_v}, 16'h0008);

    // signed overflow, then load keeps V
    alu(9'h080, 0, 0, 0); step("ovf");
    chk("tp_ovf_flg", {12'h0, flag_z, flag_n, flag_c, flag_v}, 16'h0005);
    load_en = 1; load_data = 8'h00; step("ld0");
    chk("tp_ld_flg", {12'h0, flag_z, flag_n, flag_c, flag_v}, 16'h0009);

    // overflow on subtract: 0x80 - 0x01 = 0x7F
    alu(9'h17F, 1, 0, 1); step("sub_ovf");

    // fill stack
    for (int i = 0; i < 4; i++) begin
      load_en = 1; load_data = vals[i]; step("fill_ld");
      ctx_save = 1; step("fill_push");
    end
    chk("tp_full", {15'h0, stk_full}, 16'h0001);
    load_en = 1; load_data = 8'h77; step("ld77");
    ctx_save = 1; step("push_full");
    chk("tp_full_err", {14'h0, stk_err, stk_full}, 16'h0003);

    // drain in LIFO order
    for (int i = 3; i >= 0; i--) begin
      ctx_restore = 1; step("pop");
      chk("tp_lifo", {8'h00, acc}, {8'h00, vals[i]});
    end
    ctx_restore = 1; step("pop_empty");
    chk("tp_pop_empty", {7'h0, stk_err, acc}, {7'h0, 1'b1, vals[0]});

    // simultaneous events
    reset = 0; step("rst2");
    load_en = 1; load_data = 8'h11; step("ld11");
    ctx_save = 1; alu(9'h022, 0, 0, 0); step("save_alu");
    chk("tp_save_alu", {8'h00, acc}, 16'h0022);
    ctx_restore = 1; step("restore");
    chk("tp_restore", {8'h00, acc}, 16'h0011);
    ctx_save = 1; step("save2");
    ctx_restore = 1; alu(9'h0AA, 1, 1, 0); step("restore_alu");
    chk("tp_restore_wins", {8'h00, acc}, 16'h0011);
    ctx_save = 1; step("save3");
    ctx_save = 1; ctx_restore = 1; load_en = 1; load_data = 8'h5A; step("save_restore");
    chk("tp_sr_err", {6'h0, stk_err, stk_empty, acc}, {6'h0, 1'b1, 1'b0, 8'h5A});
    ctx_restore = 1; step("pop_after_sr");
    chk("tp_sr_sp", {8'h00, acc}, 16'h0011);

    // reset mid-operation
    reset = 0; step("rst3");
    ctx_save = 1; step("p1");
    ctx_save = 1; step("p2");
    reset = 0; ctx_save = 1; alu(9'h1FF, 1, 1, 0); step("rst_mid");
    chk("tp_rst_mid", {3'h0, stk_empty, stk_full, stk_err, upd_valid, acc, flag_z},
        {3'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) != 0);
      alu_out     = 9'($urandom);
      op_a_msb    = 1'($urandom);
      op_b_msb    = 1'($urandom);
      sub_nadd    = 1'($urandom);
      alu_we      = ($urandom_range(0, 3) == 0);
      load_en     = ($urandom_range(0, 3) == 0);
      load_data   = 8'($urandom);
      ctx_save    = ($urandom_range(0, 3) == 0);
      ctx_restore = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
